// File: rtl/imm_extend_pkg.sv
// imm_extend_pkg: shared types and helpers for the immediate extender.
// Holds the extension-mode encoding, default widths and the length clamp.
package imm_extend_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

  localparam int DEF_IN_W  = 26;
  localparam int DEF_OUT_W = 32;

  // A length of zero, or one wider than the field, means "use the whole field".
  function automatic int clamp_len(input int len, input int in_w);
    return (len == 0 || len > in_w) ? in_w : len;
  endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: valid/ready bundle between decode and the extender
// (input side) and between the extender and the ALU operand mux (output side).
interface imm_extend_pipe_if #(
  parameter int IN_W  = 26,
  parameter int OUT_W = 32,
  parameter int LEN_W = $clog2(IN_W + 1)
) ();

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [LEN_W-1:0] in_len;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  // Producer of immediates and consumer of operands.
  modport master (
    output in_valid, in_data, in_len, in_mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The extender stage itself.
  modport slave (
    input  in_valid, in_data, in_len, in_mode, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/imm_extend_core.sv
// imm_extend_core: purely combinational mask / extend / shift of one
// immediate field. Also reports whether the word counts as negative
// (sign-extending mode with sign bit set).
module imm_extend_core
  import imm_extend_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int LEN_W = $clog2(IN_W + 1)
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic [LEN_W-1:0] in_len,
  input  mode_e            in_mode,
  output logic [OUT_W-1:0] result,
  output logic             neg
);

  int               eff_len;
  logic [OUT_W-1:0] mask;
  logic [OUT_W-1:0] field;
  logic [OUT_W-1:0] sext;
  logic             sign;

  // Build the field mask from the clamped length, then form each mode's result.
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    eff_len = clamp_len(int'(in_len), IN_W);
    mask    = {OUT_W{1'b1}} >> (OUT_W - eff_len);
    field   = OUT_W'(in_data) & mask;
    // The sign bit is the top set bit of the mask, picked without a variable index.
    sign    = |(field & mask & ~(mask >> 1));
    sext    = field | (sign ? ~mask : '0);
    result  = field;
    neg     = 1'b0;
    unique case (in_mode)
      MODE_ZERO:   result = field;
      MODE_SIGN:   begin
        result = sext;
        neg    = sign;
      end
      MODE_UPPER:  result = field << (OUT_W - eff_len);
      MODE_BRANCH: begin
        result = sext << 2;
        neg    = sign;
      end
      default:     result = field;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered valid/ready immediate extender with a
// 2-entry (output + skid) buffer. in_ready is a register, so neither the
// data path nor the ready path is combinational from input to output.
// Optional statistics counters are built when IMM_EXTEND_STATS_EN is defined.
module imm_extend_pipe
  import imm_extend_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int LEN_W = $clog2(IN_W + 1)
) (
  input  logic        clk,
  input  logic        rst,
  imm_extend_pipe_if.slave bus
`ifdef IMM_EXTEND_STATS_EN
  ,
  output logic [31:0] stat_xfers,
  output logic [31:0] stat_neg
`endif
);

  logic [OUT_W-1:0] ext_result;
  logic             ext_neg;

  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q,  out_data_d;
  logic             out_neg_q,   out_neg_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q,  skid_data_d;
  logic             skid_neg_q,   skid_neg_d;
  logic             in_ready_q,   in_ready_d;

  logic accept;
  logic consume;

  imm_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .in_data (bus.in_data),
    .in_len  (bus.in_len),
    .in_mode (mode_e'(bus.in_mode)),
    .result  (ext_result),
    .neg     (ext_neg)
  );

  assign accept        = bus.in_valid && in_ready_q;
  assign consume       = out_valid_q && bus.out_ready;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Decide where the next word lives: output register first, skid when stalled.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_neg_d    = out_neg_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_neg_d   = skid_neg_q;
    if (!out_valid_q || consume) begin
      // Output register is free this cycle: the older skid word has priority.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_neg_d    = skid_neg_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = ext_result;
        out_neg_d   = ext_neg;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Output stalled and a word arrives: park it in the skid register.
      skid_valid_d = 1'b1;
      skid_data_d  = ext_result;
      skid_neg_d   = ext_neg;
    end
    in_ready_d = !skid_valid_d;
  end

  // Pipeline state register; reset discards both held words at once.
  // NOTE: the data registers are reset as well, because out_data must read
  // zero during reset; they are plain flops, not a memory array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_neg_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_neg_q   <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before the edge, independent of statement order.
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_neg_q    <= out_neg_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_neg_q   <= skid_neg_d;
      in_ready_q   <= in_ready_d;
    end
  end

`ifdef IMM_EXTEND_STATS_EN
  // Count consumed words, and consumed words that were sign-extended negatives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_xfers <= '0;
      stat_neg   <= '0;
    end else if (consume) begin
      stat_xfers <= stat_xfers + 32'd1;
      if (out_neg_q) begin
        stat_neg <= stat_neg + 32'd1;
      end
    end
  end
`else
  // The negative flag only feeds the statistics counters.
  logic unused_stats;
  assign unused_stats = out_neg_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: scoreboard bench for imm_extend_pipe. Stimulus pushes
// model results into a queue; a negedge monitor pops and compares on each
// output handshake and checks that stalled output data stays stable.
module tb_imm_extend_pipe;

  localparam int IN_W  = 26;
  localparam int OUT_W = 32;
  localparam int LEN_W = $clog2(IN_W + 1);

  typedef struct {
    logic [OUT_W-1:0] data;
    bit               neg;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) bus ();

`ifdef IMM_EXTEND_STATS_EN
  logic [31:0] stat_xfers;
  logic [31:0] stat_neg;
`endif

  imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef IMM_EXTEND_STATS_EN
    ,
    .stat_xfers (stat_xfers),
    .stat_neg   (stat_neg)
`endif
  );

  exp_t exp_q[$];
  int   checks      = 0;
  int   failures    = 0;
  int   n_pop       = 0;
  int   exp_neg_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: value of the field as an integer, then arithmetic per mode.
  function automatic logic [OUT_W-1:0] ref_ext(input logic [IN_W-1:0] d, input int len,
                                                input int mode, output bit neg);
    int     l;
    longint f, v, r;
    bit     s;
    l = (len == 0 || len > IN_W) ? IN_W : len;
    f = longint'(d) % (longint'(1) << l);
    s = (f >= (longint'(1) << (l - 1)));
    v = s ? f - (longint'(1) << l) : f;
    case (mode)
      0:       r = f;
      1:       r = v;
      2:       r = f * (longint'(1) << (OUT_W - l));
      default: r = v * 4;
    endcase
    neg = s && (mode == 1 || mode == 3);
    return OUT_W'(r);
  endfunction

  // Offer one word; return just after the accepting edge. stalled reports
  // whether in_ready was low when the word was first offered.
  task automatic send(input logic [IN_W-1:0] d, input int len, input int mode, output bit stalled);
    int   budget = 50;
    exp_t e;
    bit   neg;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_len   = LEN_W'(len);
    bus.in_mode  = 2'(mode);
    e.data  = ref_ext(d, len, mode, neg);
    e.neg   = neg;
    stalled = 1'b0;
    while (!bus.in_ready && budget > 0) begin
      stalled = 1'b1;
      @(posedge clk); #1;
      budget--;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 60;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_stats(input string tag);
`ifdef IMM_EXTEND_STATS_EN
    check({tag, "_stat_xfers"}, 64'(stat_xfers), 64'(n_pop));
    check({tag, "_stat_neg"}, 64'(stat_neg), 64'(exp_neg_cnt));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Monitor: compare on every output handshake, and check hold stability.
  bit               stalled_out = 1'b0;
  logic [OUT_W-1:0] held_data;
  always @(negedge clk) begin
    if (rst) begin
      stalled_out = 1'b0;
    end else if (bus.out_valid) begin
      if (stalled_out) check("hold_stable", 64'(bus.out_data), 64'(held_data));
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(bus.out_valid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", 64'(bus.out_data), 64'(e.data));
          n_pop++;
          if (e.neg) exp_neg_cnt++;
        end
        stalled_out = 1'b0;
      end else begin
        stalled_out = 1'b1;
        held_data   = bus.out_data;
      end
    end else begin
      stalled_out = 1'b0;
    end
  end

  // Random out_ready toggling, enabled only during the mixed-traffic phase.
  bit rnd_bp = 1'b0;
  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit st;
    int stalls;
    int pop_base;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_len    = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);
    check_stats("post_rst");

    // Directed mode vectors with the consumer always ready.
    bus.out_ready = 1'b1;
    send(26'h000002D, 6, 0, st);
    check("latency_valid", 64'(bus.out_valid), 64'd1);
    check("latency_data", 64'(bus.out_data), 64'h0000002D);
    send(26'h2AB8001, 16, 1, st);
    send(26'h2AB8001, 16, 0, st);
    send(26'h0001234, 16, 2, st);
    send(26'h000FFFF, 16, 3, st);
    send(26'h3FFFFFF, 0,  1, st);
    idle();
    drain();

    // Backpressure: A to output, B to skid, C refused while stalled.
    bus.out_ready = 1'b0;
    send(26'h0000015, 5, 1, st);
    send(26'h00000AB, 8, 3, st);
    bus.in_valid = 1'b1;
    bus.in_data  = 26'h0000C0;
    bus.in_len   = LEN_W'(8);
    bus.in_mode  = 2'b10;
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    check("bp_hold_A", 64'(bus.out_data), 64'hFFFFFFF5);
    repeat (2) @(posedge clk);
    #1;
    check("bp_still_blocked", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    send(26'h00000C0, 8, 2, st);
    check("bp_no_gap", 64'(bus.out_valid), 64'd1);
    idle();
    drain();

    // Full throughput: 100 back-to-back words, in_ready must never drop.
    stalls   = 0;
    pop_base = n_pop;
    for (int i = 0; i < 100; i++) begin
      send(IN_W'($urandom), $urandom_range(0, 31), $urandom_range(0, 3), st);
      if (st) stalls++;
    end
    idle();
    drain();
    check("tput_stalls", 64'(stalls), 64'd0);
    check("tput_count", 64'(n_pop - pop_base), 64'd100);

    // Mixed traffic: random input gaps and random consumer backpressure.
    rnd_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end
      send(IN_W'($urandom), $urandom_range(0, 31), $urandom_range(0, 3), st);
    end
    idle();
    rnd_bp = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain();
    @(posedge clk); #1;
    check_stats("mixed");

    // Reset between clock edges with both entries full.
    bus.out_ready = 1'b0;
    send(26'h0000111, 12, 1, st);
    send(26'h0000222, 12, 3, st);
    idle();
    #3;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    check("midrst_out_data", 64'(bus.out_data), 64'd0);
    exp_q.delete();
    n_pop       = 0;
    exp_neg_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_in_ready_back", 64'(bus.in_ready), 64'd1);
    check_stats("midrst");
    bus.out_ready = 1'b1;
    send(26'h0000ABC, 12, 1, st);
    check("midrst_first_valid", 64'(bus.out_valid), 64'd1);
    check("midrst_first_data", 64'(bus.out_data), 64'hFFFFFABC);
    idle();
    drain();
    @(posedge clk); #1;
    check_stats("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised immediate-field extender for the KGP RISC datapath; successor to the fixed 6-to-32 zero padder.
- Takes a variable-length immediate field of up to IN_W bits and produces an OUT_W-bit operand.
- Four modes: zero-extend, sign-extend, upper-placement (LUI style), sign-extend plus shift-left-2 (branch offset).
- Registered, valid/ready pipeline stage with a 2-entry skid buffer, sitting between decode and the ALU operand mux.

Parameters:
- IN_W, 26: maximum immediate field width, in bits.
- OUT_W, 32: output operand width. Must satisfy OUT_W >= IN_W+2.
- LEN_W, $clog2(IN_W+1): width of the in_len field.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  stage can accept a word.
- in_data  input  IN_W  raw field; bits at index >= effective length are ignored.
- in_len  input  LEN_W  number of meaningful low bits.
- in_mode  input  2  00 zero, 01 sign, 10 upper, 11 branch.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  OUT_W  extended result.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (clk, rst).
  - While rst is high: out_valid=0, out_data=0, skid buffer empty, in_ready=0.
  - in_ready rises in the first cycle after rst deasserts.
  - Reset asserted mid-transfer discards all held words immediately, without waiting for a clock edge.
- Effective length L = in_len, except in_len==0 or in_len>IN_W, which is clamped to IN_W.
- Field f = in_data masked to its low L bits. Sign bit s = in_data[L-1].
- Mode results:
  - 00: f, zero-padded to OUT_W.
  - 01: f with s replicated into bits OUT_W-1..L.
  - 10: f << (OUT_W-L); low bits zero.
  - 11: sign-extended f << 2, truncated to OUT_W.
- Input handshake: a word is accepted when in_valid && in_ready.
- Latency: an accepted word appears on out_data with out_valid=1 at the next rising edge. No combinational path runs from input to output.
- Output handshake: a word is consumed when out_valid && out_ready. out_data is held stable while out_valid && !out_ready.
- Storage: output register plus one skid register.
  - in_ready = !skid_valid (registered, with no combinational dependency on out_ready).
  - Output register full, not consumed, and a new word accepted: the new word goes to the skid register.
  - When the output register is consumed, it loads from the skid register if the skid holds a word; otherwise it loads from the input.
  - Simultaneous accept and consume with the skid empty: the output register reloads directly from the input, giving full throughput.
  - Order is always preserved; no word is ever dropped or duplicated.
- in_mode and in_len are sampled only on acceptance.

Optional Feature:
- Macro: IMM_EXTEND_STATS_EN.
- Defined: adds output stat_xfers (32-bit), counting consumed words, and output stat_neg (32-bit), counting consumed words whose mode was 01 or 11 with s=1.
  - Both counters reset to 0 and wrap modulo 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package imm_extend_pkg holds:
  - mode enum: MODE_ZERO=2'b00, MODE_SIGN=2'b01, MODE_UPPER=2'b10, MODE_BRANCH=2'b11;
  - default widths 26/32;
  - the length-clamp function.
- One sub-module, imm_extend_core: purely combinational mask/extend/shift logic.
- The top level holds the handshake, skid buffer and optional counters.

Test Plan:
- Zero-extend: in_data=0x000002D, len=6, mode=00, out_ready=1 -> out_data=0x0000002D, one cycle after acceptance.
- Sign-extend with junk upper bits: in_data=0x2AB8001, len=16, mode=01 -> 0xFFFF8001. Repeat with mode=00 -> 0x00008001.
- Upper and branch modes:
  - len=16, data=0x1234, mode=10 -> 0x12340000.
  - len=16, data=0xFFFF, mode=11 -> 0xFFFFFFFC.
  - len=0 (clamp to 26), data=0x3FFFFFF, mode=01 -> 0xFFFFFFFF.
- Backpressure: hold out_ready=0 and offer words A, B, C on consecutive cycles -> A and B are accepted, in_ready=0 on the C cycle, A is held stable. Release out_ready -> outputs A, B, C in order, with no gap once streaming.
- Full throughput: in_valid=out_ready=1 for 100 cycles with random data -> 100 outputs matching the model, in_ready never deasserts.
- Reset mid-stream with both entries full: raise rst between clock edges -> out_valid=0 immediately. After release, the first new word emerges correctly; with IMM_EXTEND_STATS_EN defined, the counters read 0.
